// File: rtl/projeto_nios_keys_pio.sv
// Avalon-MM input PIO for keys/switches: synchroniser, optional debounce, edge capture, masked irq.
// Define PIO_KEYS_DEBOUNCE_EN to insert the per-bit debounce filter.
module projeto_nios_keys_pio #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_t;

  logic [WIDTH-1:0] sync1, sync2, stable, prev;
  logic [WIDTH-1:0] irq_mask, edge_capture, edge_det, clr;
  logic [1:0]       warm;
  logic             rd_en, wr_en;
  reg_addr_t        reg_sel;
  logic             unused_wdata;

  assign rd_en        = chipselect && write_n;
  assign wr_en        = chipselect && !write_n;
  assign reg_sel      = reg_addr_t'(address);
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_KEYS_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt [WIDTH];

  // A bit's new level is accepted only after it has differed from stable for DEBOUNCE_CYCLES clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable <= '0;
    else          stable <= sync2;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
      warm <= '0;
    end else begin
      prev <= stable;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  // Warm-up gating keeps the pipeline filling after reset from looking like input edges.
  always_comb begin
    edge_det = '0;
    clr      = '0;
    case (EDGE_TYPE)
      0:       edge_det = stable & ~prev;
      1:       edge_det = ~stable & prev;
      default: edge_det = stable ^ prev;
    endcase
    if (warm != 2'd3) edge_det = '0;
    if (wr_en && reg_sel == ADDR_EDGECAP) clr = writedata[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && reg_sel == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr) | edge_det;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd_en) begin
      case (reg_sel)
        ADDR_DATA:    readdata <= 32'(stable);
        ADDR_IRQMASK: readdata <= 32'(irq_mask);
        ADDR_EDGECAP: readdata <= 32'(edge_capture);
        default:      readdata <= '0;
      endcase
    end else begin
      readdata <= '0;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_projeto_nios_keys_pio.sv
// Self-checking bench for projeto_nios_keys_pio: delay-line reference model checked every cycle plus directed literals.
module tb_projeto_nios_keys_pio;
  localparam int DB = 8;
`ifdef PIO_KEYS_DEBOUNCE_EN
  localparam int CAPK   = DB + 2;
  localparam int SETTLE = DB + 4;
`else
  localparam int CAPK   = 3;
  localparam int SETTLE = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  projeto_nios_keys_pio #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: input samples in a delay line, filtered level, capture, mask, read data.
  logic [3:0]  hist[$];
  logic [3:0]  m_st, m_pv, m_mask, m_cap;
  logic [31:0] m_rd;
  int          nedges;
  int          run[4];

  task automatic model_reset();
    hist.delete();
    m_st = '0; m_pv = '0; m_mask = '0; m_cap = '0; m_rd = '0; nedges = 0;
    for (int b = 0; b < 4; b++) run[b] = 0;
  endtask

  task automatic model_step(input logic [3:0] din, input logic cs, input logic wn,
                            input logic [1:0] a, input logic [31:0] wd);
    logic [3:0] s2, e, clr;
    s2 = (hist.size() >= 2) ? hist[hist.size()-2] : 4'h0;
    e  = ~m_st & m_pv;
    if (nedges < 3) e = '0;
    m_rd = '0;
    if (cs && wn) begin
      case (a)
        2'd0: m_rd = {28'h0, m_st};
        2'd2: m_rd = {28'h0, m_mask};
        2'd3: m_rd = {28'h0, m_cap};
        default: m_rd = '0;
      endcase
    end
    clr = (cs && !wn && a == 2'd3) ? wd[3:0] : 4'h0;
    m_cap = (m_cap & ~clr) | e;
    if (cs && !wn && a == 2'd2) m_mask = wd[3:0];
    m_pv = m_st;
`ifdef PIO_KEYS_DEBOUNCE_EN
    for (int b = 0; b < 4; b++) begin
      if (s2[b] == m_st[b]) run[b] = 0;
      else begin
        run[b]++;
        if (run[b] == DB) begin
          m_st[b] = s2[b];
          run[b]  = 0;
        end
      end
    end
`else
    m_st = s2;
`endif
    hist.push_back(din);
    if (hist.size() > 4) void'(hist.pop_front());
    if (nedges < 3) nedges++;
  endtask

  initial begin
    logic [3:0]  s_in;
    logic        s_rst, s_cs, s_wn;
    logic [1:0]  s_a;
    logic [31:0] s_wd;
    model_reset();
    forever begin
      @(posedge clk);
      s_in = in_port; s_rst = reset_n; s_cs = chipselect; s_wn = write_n;
      s_a = address; s_wd = writedata;
      @(negedge clk);
      if (s_rst !== 1'b1) model_reset();
      else model_step(s_in, s_cs, s_wn, s_a, s_wd);
      if (reset_n !== 1'b1) model_reset();
      chk("model_readdata", readdata, m_rd);
      chk("model_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    cyc();
    chipselect = 1'b0;
    chk(nm, readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0;
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;

    // Inputs held high through reset
    repeat (SETTLE) cyc();
    bus_read(2'd0, 32'hF, "t1_data");
    bus_read(2'd3, 32'h0, "t1_edgecap");
    chk("t1_irq", {31'h0, irq}, 32'h0);

    // Falling edge on bit1 with bit1 unmasked
    bus_write(2'd2, 32'h2);
    in_port = 4'hD;
    repeat (SETTLE) cyc();
    bus_read(2'd3, 32'h2, "t2_edgecap");
    chk("t2_irq", {31'h0, irq}, 32'h1);

    // W1C clear, then a clear colliding with a new edge
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, 32'h0, "t3_cleared");
    chk("t3_irq", {31'h0, irq}, 32'h0);
    in_port = 4'hF;
    repeat (SETTLE) cyc();
    in_port = 4'hD;
    repeat (CAPK) cyc();
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, 32'h2, "t3_set_wins");
    bus_write(2'd3, 32'h2);

    // Masked edges on bits 0 and 3
    bus_write(2'd2, 32'h0);
    in_port = 4'h4;
    repeat (SETTLE) cyc();
    bus_read(2'd3, 32'h9, "t4_edgecap");
    chk("t4_irq_masked", {31'h0, irq}, 32'h0);
    bus_write(2'd2, 32'h8);
    chk("t4_irq_unmasked", {31'h0, irq}, 32'h1);

    // Register map corners
    bus_read(2'd1, 32'h0, "t5_addr1");
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, 32'h4, "t5_data_ro");
    chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
    cyc();
    chk("t5_b2b_data", readdata, 32'h4);
    address = 2'd2;
    cyc();
    chk("t5_b2b_mask", readdata, 32'h8);
    chipselect = 1'b0;
    cyc();
    chk("t5_idle_zero", readdata, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, 32'hF, "t5_mask_width");

    // Asynchronous reset mid-operation
    chk("t7_irq_before", {31'h0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("t7_irq_reset", {31'h0, irq}, 32'h0);
    cyc();
    reset_n = 1'b1;
    repeat (SETTLE) cyc();
    bus_read(2'd3, 32'h0, "t7_edgecap");
    bus_read(2'd2, 32'h0, "t7_mask");
    bus_read(2'd0, 32'h4, "t7_data");

`ifdef PIO_KEYS_DEBOUNCE_EN
    in_port = 4'hF;
    repeat (SETTLE) cyc();
    bus_read(2'd0, 32'hF, "t6_high");
    in_port = 4'hE;
    repeat (5) cyc();
    in_port = 4'hF;
    repeat (SETTLE) cyc();
    bus_read(2'd0, 32'hF, "t6_glitch_rejected");
    in_port = 4'hE;
    repeat (20) cyc();
    bus_read(2'd0, 32'hE, "t6_low_accepted");
`endif

    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
